svc_axi_sram_if_rd_q: RTL and testbench
=======================================

# svc_axi_sram_if_rd_q

AXI read-channel front end for an SRAM-like subordinate. It accepts multiple outstanding AR requests through an internal queue. It expands each into single-word SRAM read commands with FIXED, INCR and optional WRAP addressing, and issues consecutive bursts with no idle cycle between them. Read data passes straight through to the AXI R channel. It sits between an AXI interconnect port and an SRAM controller, as the pipelined successor of the single-outstanding read adapter.

## Interface
- AXI_ADDR_WIDTH, 20, AXI byte address width
- AXI_DATA_WIDTH, 16, data width; power of 2, ≥16
- AXI_ID_WIDTH, 4, ID width
- AR_DEPTH, 4, pending AR queue entries (power of 2, ≥2), excluding the active burst
- LSB, $clog2(AXI_DATA_WIDTH)-3, byte-to-word shift
- SRAM_ADDR_WIDTH, AXI_ADDR_WIDTH-LSB, word address width
- SRAM_DATA_WIDTH, AXI_DATA_WIDTH, SRAM data width
- SRAM_META_WIDTH, AXI_ID_WIDTH, metadata width (carries ID)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- s_axi_arvalid/arready  in/out  1  AR handshake
- s_axi_arid  in  AXI_ID_WIDTH
- s_axi_araddr  in  AXI_ADDR_WIDTH
- s_axi_arlen  in  8
- s_axi_arsize  in  3
- s_axi_arburst  in  2
- s_axi_rvalid/rready  out/in  1  R handshake
- s_axi_rid  out  AXI_ID_WIDTH
- s_axi_rdata  out  AXI_DATA_WIDTH
- s_axi_rresp  out  2  always 2'b00
- s_axi_rlast  out  1
- sram_rd_cmd_valid/ready  out/in  1
- sram_rd_cmd_addr  out  SRAM_ADDR_WIDTH  word address = addr[AXI_ADDR_WIDTH-1:LSB]
- sram_rd_cmd_meta  out  SRAM_META_WIDTH  burst ID
- sram_rd_cmd_last  out  1  final beat of the burst
- sram_rd_resp_valid/ready  in/out  1
- sram_rd_resp_data  in  SRAM_DATA_WIDTH
- sram_rd_resp_meta  in  SRAM_META_WIDTH
- sram_rd_resp_last  in  1
- busy  out  1  active burst or non-empty queue

## Operation
- AR queue: FIFO of {id, addr, len, size, burst}. Push on arvalid&&arready. s_axi_arready = registered !full.
- Size clamp: stored size = min(arsize, $clog2(AXI_DATA_WIDTH/8)).
- Engine states: IDLE and BURST.
  - IDLE: if the queue is non-empty, pop an entry, load the engine and go to BURST.
  - BURST: on cmd_valid&&cmd_ready, advance the address and decrement remaining. On the last beat, pop the next entry in the same cycle if one is present and stay in BURST; otherwise go to IDLE.
- Address step (8-bit remaining count, AXI_ADDR_WIDTH address arithmetic, truncated on overflow):
  - FIXED (00): address unchanged.
  - INCR (01) and reserved (11): next = (addr & ~((1<<size)-1)) + (1<<size).
  - WRAP (10): mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+(1<<size)) & mask). Legal only for len ∈ {1,3,7,15}. Any other len is treated as INCR.
- cmd_last = 1 exactly when remaining == 0. cmd_meta = burst ID.
- Response passthrough, purely combinational:
  - rvalid = resp_valid, rdata = resp_data, rid = resp_meta, rlast = resp_last.
  - resp_ready = rready.

## Timing
- Reset values: arready 0, cmd_valid 0, busy 0, engine IDLE, queue empty. arready rises in the first clk edge after rst deasserts.
- Latency, AR accepted at edge t into an empty queue with an idle engine: entry popped at t+1, cmd_valid high at t+2 with the first address.
- Back-to-back bursts: the last beat of burst N is accepted at edge t and the first beat of burst N+1 is valid immediately after t, with no bubble.
- cmd_valid, addr, meta and last are stable while cmd_ready is low.
- Queue full and pop in the same cycle: arready deasserts only if the count after the edge equals AR_DEPTH. Simultaneous push and pop keeps the count unchanged.
- Reset mid-burst: the engine and queue are cleared immediately (asynchronously). Outstanding SRAM responses still pass through unchanged.
- The R path adds zero cycles.

## Configuration
- SVC_AXI_SRAM_IF_RD_Q_WRAP_EN
  - Defined: WRAP addressing as specified above.
  - Undefined: burst 10 is treated as INCR and the mask logic is removed.

## Test plan
- Single beat: araddr=0x0010, len=0, INCR, id=3 → one cmd with addr=0x0008, meta=3, last=1; response data 0xBEEF → rdata=0xBEEF, rid=3, rlast=1.
- Back-to-back bursts: two INCR len=3 ARs at 0x0000 and 0x0100 with cmd_ready held at 1 → word addresses 0,1,2,3,0x80,0x81,0x82,0x83 on 8 consecutive cycles; last set on beats 4 and 8.
- FIXED: araddr=0x0020, len=2 → three cmds, each addr=0x0010; last set only on the third.
- WRAP (macro defined): araddr=0x0006, len=3, size=1 → word addresses 3,0,1,2. Same stimulus with the macro undefined → 3,4,5,6.
- Queue full: AR_DEPTH=4, cmd_ready=0, issue 6 ARs → 5 accepted, arready low; one cmd accept → arready high on the next cycle.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst → cmd_valid=0, arready=0, busy=0 without waiting for a clock edge. After release, a new AR is served correctly.

Source files
------------

// File: rtl/svc_axi_sram_if_rd_q.sv
// AXI read front end: queued AR requests expanded into single-word SRAM read commands.
// Optional WRAP addressing is enabled by defining SVC_AXI_SRAM_IF_RD_Q_WRAP_EN.
module svc_axi_sram_if_rd_q #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int AR_DEPTH        = 4,
  parameter int LSB             = $clog2(AXI_DATA_WIDTH) - 3,
  parameter int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - LSB,
  parameter int SRAM_DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int SRAM_META_WIDTH = AXI_ID_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       sram_rd_cmd_valid,
  input  logic                       sram_rd_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_cmd_addr,
  output logic [SRAM_META_WIDTH-1:0] sram_rd_cmd_meta,
  output logic                       sram_rd_cmd_last,
  input  logic                       sram_rd_resp_valid,
  output logic                       sram_rd_resp_ready,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_resp_data,
  input  logic [SRAM_META_WIDTH-1:0] sram_rd_resp_meta,
  input  logic                       sram_rd_resp_last,
  output logic                       busy,
  output logic                       o_dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid && ready; a
  // producer holds valid and payload stable until the transfer completes.

  localparam int          MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);
  localparam int          PW       = $clog2(AR_DEPTH);
  localparam int          EW       = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2;
  localparam logic [2:0]  MAX_SZ   = 3'(MAX_SIZE);
  localparam logic [PW:0] DEPTH_C  = (PW + 1)'(AR_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t r_state, w_state_next;

  logic [EW-1:0]             r_mem [AR_DEPTH];
  logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [PW:0]               r_count, w_count_next;
  logic                      r_arready;
  logic                      w_push, w_pop, w_empty, w_fire;
  logic [2:0]                w_ar_size;

  logic [AXI_ID_WIDTH-1:0]   w_h_id;
  logic [AXI_ADDR_WIDTH-1:0] w_h_addr;
  logic [7:0]                w_h_len;
  logic [2:0]                w_h_size;
  logic [1:0]                w_h_burst;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, w_next_addr, w_step, w_incr;
  logic [7:0]                r_rem;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;

  assign w_push       = s_axi_arvalid && r_arready;
  assign w_empty      = (r_count == '0);
  assign w_fire       = sram_rd_cmd_valid && sram_rd_cmd_ready;
  assign w_ar_size    = (s_axi_arsize > MAX_SZ) ? MAX_SZ : s_axi_arsize;
  assign w_count_next = r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
  assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axi_arid, s_axi_araddr, s_axi_arlen, w_ar_size, s_axi_arburst};
    end
  end

  // arready looks at the post-edge count so a same-cycle pop frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_arready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_next;
      r_arready <= (w_count_next != DEPTH_C);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (w_fire && (r_rem == 8'd0)) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_step = AXI_ADDR_WIDTH'(1) << r_size;
  assign w_incr = (r_addr & ~(w_step - AXI_ADDR_WIDTH'(1))) + w_step;

`ifdef SVC_AXI_SRAM_IF_RD_Q_WRAP_EN
  logic [7:0]                r_len;
  logic [AXI_ADDR_WIDTH-1:0] w_mask, w_wrap;
  logic                      w_wrap_ok;

  assign w_wrap_ok = (r_burst == 2'b10) &&
                     ((r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15));
  assign w_mask    = ((AXI_ADDR_WIDTH'(r_len) + AXI_ADDR_WIDTH'(1)) << r_size) - AXI_ADDR_WIDTH'(1);
  assign w_wrap    = (r_addr & ~w_mask) | ((r_addr + w_step) & w_mask);

  always_comb begin
    w_next_addr = w_incr;
    if (r_burst == 2'b00) w_next_addr = r_addr;
    else if (w_wrap_ok)   w_next_addr = w_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_len <= '0;
    else if (w_pop) r_len <= w_h_len;
  end
`else
  assign w_next_addr = (r_burst == 2'b00) ? r_addr : w_incr;
`endif

  // A pop on the last beat reloads the engine, giving bubble-free bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_id    <= w_h_id;
        r_addr  <= w_h_addr;
        r_rem   <= w_h_len;
        r_size  <= w_h_size;
        r_burst <= w_h_burst;
      end else if (w_fire) begin
        r_addr  <= w_next_addr;
        r_rem   <= r_rem - 8'd1;
      end
    end
  end

  assign s_axi_arready      = r_arready;
  assign sram_rd_cmd_valid  = (r_state == S_BURST);
  assign sram_rd_cmd_addr   = r_addr[AXI_ADDR_WIDTH-1:LSB];
  assign sram_rd_cmd_meta   = r_id;
  assign sram_rd_cmd_last   = (r_rem == 8'd0);
  assign busy               = (r_state != S_IDLE) || !w_empty;
  assign o_dbg_state        = r_state;

  assign s_axi_rvalid       = sram_rd_resp_valid;
  assign s_axi_rdata        = sram_rd_resp_data;
  assign s_axi_rid          = sram_rd_resp_meta;
  assign s_axi_rlast        = sram_rd_resp_last;
  assign s_axi_rresp        = 2'b00;
  assign sram_rd_resp_ready = s_axi_rready;

endmodule

// File: tb/tb_svc_axi_sram_if_rd_q.sv
// Directed bench for svc_axi_sram_if_rd_q: AR vector table with hand-computed
// word addresses, plus back-to-back, queue-full and reset-mid-burst sequences.
module tb_svc_axi_sram_if_rd_q;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int SAW = 19;
  localparam int EW  = SAW + IW + 1;

  logic            clk, rst;
  logic            s_axi_arvalid, s_axi_arready;
  logic [IW-1:0]   s_axi_arid;
  logic [AW-1:0]   s_axi_araddr;
  logic [7:0]      s_axi_arlen;
  logic [2:0]      s_axi_arsize;
  logic [1:0]      s_axi_arburst;
  logic            s_axi_rvalid, s_axi_rready;
  logic [IW-1:0]   s_axi_rid;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            sram_rd_cmd_valid, sram_rd_cmd_ready;
  logic [SAW-1:0]  sram_rd_cmd_addr;
  logic [IW-1:0]   sram_rd_cmd_meta;
  logic            sram_rd_cmd_last;
  logic            sram_rd_resp_valid, sram_rd_resp_ready;
  logic [DW-1:0]   sram_rd_resp_data;
  logic [IW-1:0]   sram_rd_resp_meta;
  logic            sram_rd_resp_last;
  logic            busy;
  logic            o_dbg_state;

  svc_axi_sram_if_rd_q dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .sram_rd_cmd_valid(sram_rd_cmd_valid), .sram_rd_cmd_ready(sram_rd_cmd_ready),
    .sram_rd_cmd_addr(sram_rd_cmd_addr), .sram_rd_cmd_meta(sram_rd_cmd_meta),
    .sram_rd_cmd_last(sram_rd_cmd_last),
    .sram_rd_resp_valid(sram_rd_resp_valid), .sram_rd_resp_ready(sram_rd_resp_ready),
    .sram_rd_resp_data(sram_rd_resp_data), .sram_rd_resp_meta(sram_rd_resp_meta),
    .sram_rd_resp_last(sram_rd_resp_last),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_vec_t;

  ar_vec_t        ar_tab [9];
  logic [SAW-1:0] exp_word [27];
  logic [EW-1:0]  exp_q [$];

  int   n_tests, n_fail;
  int   cyc, fire_cnt, fire_first, fire_last;
  logic ar_fired, sb_en, bp_en, stall_prev;
  logic [EW-1:0] stall_val;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard + hold checks), drive at posedge+1.
  task automatic step();
    logic [EW-1:0] cur, e;
    @(negedge clk);
    cyc++;
    ar_fired = s_axi_arvalid && s_axi_arready;
    cur = {sram_rd_cmd_addr, sram_rd_cmd_meta, sram_rd_cmd_last};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("cmd_hold_valid", sram_rd_cmd_valid, 1);
        check("cmd_hold_payload", cur, stall_val);
      end
      if (sram_rd_cmd_valid && sram_rd_cmd_ready) begin
        if (fire_cnt == 0) fire_first = cyc;
        fire_last = cyc;
        fire_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_unexpected: got 0x%0h, expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("cmd_beat", cur, e);
          end
        end
      end
      stall_prev = sram_rd_cmd_valid && !sram_rd_cmd_ready;
      stall_val  = cur;
    end
    @(posedge clk);
    #1;
    if (bp_en) sram_rd_cmd_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic ar_send(input ar_vec_t v);
    int n;
    s_axi_arid    = v.id;
    s_axi_araddr  = v.addr;
    s_axi_arlen   = v.len;
    s_axi_arsize  = v.size;
    s_axi_arburst = v.burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!ar_fired && n < 100);
    check("ar_accept", ar_fired, 1);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic push_exp(input ar_vec_t v, input int first);
    for (int b = 0; b <= int'(v.len); b++)
      exp_q.push_back({exp_word[first + b], v.id, (b == int'(v.len))});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_queue_left", exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int e, acc;
    ar_vec_t v;
    n_tests = 0; n_fail = 0; cyc = 0; fire_cnt = 0; fire_first = 0; fire_last = 0;
    ar_fired = 0; sb_en = 1; bp_en = 0; stall_prev = 0; stall_val = '0;

    ar_tab[0] = '{id: 4'd3,  addr: 20'h00010, len: 8'd0, size: 3'd1, burst: 2'b01};
    ar_tab[1] = '{id: 4'd5,  addr: 20'h00020, len: 8'd2, size: 3'd1, burst: 2'b00};
    ar_tab[2] = '{id: 4'd6,  addr: 20'h00006, len: 8'd3, size: 3'd1, burst: 2'b10};
    ar_tab[3] = '{id: 4'd7,  addr: 20'h00002, len: 8'd1, size: 3'd3, burst: 2'b01};
    ar_tab[4] = '{id: 4'd8,  addr: 20'h00003, len: 8'd1, size: 3'd1, burst: 2'b11};
    ar_tab[5] = '{id: 4'd9,  addr: 20'h00006, len: 8'd2, size: 3'd1, burst: 2'b10};
    ar_tab[6] = '{id: 4'd10, addr: 20'h00004, len: 8'd1, size: 3'd0, burst: 2'b01};
    ar_tab[7] = '{id: 4'd15, addr: 20'hFFFFE, len: 8'd1, size: 3'd1, burst: 2'b01};
    ar_tab[8] = '{id: 4'd2,  addr: 20'h0000C, len: 8'd7, size: 3'd1, burst: 2'b10};
    exp_word = '{19'h8, 19'h10, 19'h10, 19'h10, 19'h3, 19'h4, 19'h5, 19'h6,
                 19'h1, 19'h2, 19'h1, 19'h2, 19'h3, 19'h4, 19'h5, 19'h2, 19'h2,
                 19'h7FFFF, 19'h0, 19'h6, 19'h7, 19'h8, 19'h9, 19'hA, 19'hB, 19'hC, 19'hD};
`ifdef SVC_AXI_SRAM_IF_RD_Q_WRAP_EN
    exp_word[5] = 19'h0; exp_word[6] = 19'h1; exp_word[7] = 19'h2;
    exp_word[21] = 19'h0; exp_word[22] = 19'h1; exp_word[23] = 19'h2;
    exp_word[24] = 19'h3; exp_word[25] = 19'h4; exp_word[26] = 19'h5;
`endif

    rst = 1'b1;
    s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0;
    s_axi_arsize = 0; s_axi_arburst = 0; s_axi_rready = 1;
    sram_rd_cmd_ready = 0; sram_rd_resp_valid = 0; sram_rd_resp_data = 0;
    sram_rd_resp_meta = 0; sram_rd_resp_last = 0;
    #1;
    check("rst_arready", s_axi_arready, 0);
    check("rst_cmd_valid", sram_rd_cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", o_dbg_state, 0);
    check("rresp_zero", s_axi_rresp, 0);
    step(); step();
    rst = 1'b0;
    #1 check("arready_before_edge", s_axi_arready, 0);
    step();
    check("arready_after_edge", s_axi_arready, 1);

    // Vector table: each AR expanded, with random command backpressure.
    bp_en = 1;
    e = 0;
    for (int r = 0; r < 9; r++) begin
      push_exp(ar_tab[r], e);
      e += int'(ar_tab[r].len) + 1;
      ar_send(ar_tab[r]);
      check("cmd_not_same_cycle", sram_rd_cmd_valid, 0);
      drain();
      if (r == 0) begin
        sram_rd_resp_valid = 1; sram_rd_resp_data = 16'hBEEF;
        sram_rd_resp_meta = 4'd3; sram_rd_resp_last = 1; s_axi_rready = 1;
        #1;
        check("r_valid", s_axi_rvalid, 1);
        check("r_data", s_axi_rdata, 16'hBEEF);
        check("r_id", s_axi_rid, 3);
        check("r_last", s_axi_rlast, 1);
        check("resp_ready_hi", sram_rd_resp_ready, 1);
        s_axi_rready = 0;
        #1 check("resp_ready_lo", sram_rd_resp_ready, 0);
        s_axi_rready = 1; sram_rd_resp_valid = 0; sram_rd_resp_last = 0;
      end
    end

    // Back-to-back bursts, cmd_ready held high.
    bp_en = 0; sram_rd_cmd_ready = 1; fire_cnt = 0;
    v = '{id: 4'd1, addr: 20'h00000, len: 8'd3, size: 3'd1, burst: 2'b01};
    for (int b = 0; b < 4; b++) exp_q.push_back({19'(b), 4'd1, (b == 3)});
    ar_send(v);
    v = '{id: 4'd4, addr: 20'h00100, len: 8'd3, size: 3'd1, burst: 2'b01};
    for (int b = 0; b < 4; b++) exp_q.push_back({19'(8'h80 + b), 4'd4, (b == 3)});
    ar_send(v);
    drain();
    check("b2b_beats", fire_cnt, 8);
    check("b2b_span", fire_last - fire_first, 7);

    // Queue full: engine holds one, queue holds AR_DEPTH.
    sram_rd_cmd_ready = 0; acc = 0;
    for (int k = 0; k < 6; k++) exp_q.push_back({19'(k * 8), 4'(k), 1'b1});
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 1;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ar_fired) begin
        acc++;
        s_axi_arid = 4'(acc);
        s_axi_araddr = 20'(acc * 16);
      end
    end
    check("full_accepted", acc, 5);
    check("full_arready", s_axi_arready, 0);
    check("full_busy", busy, 1);
    sram_rd_cmd_ready = 1;
    step();
    sram_rd_cmd_ready = 0;
    check("full_arready_reopen", s_axi_arready, 1);
    step();
    check("full_sixth_accept", ar_fired, 1);
    s_axi_arvalid = 0;
    bp_en = 1;
    drain();

    // Reset during beat 2 of an 8-beat burst.
    bp_en = 0; sb_en = 0; sram_rd_cmd_ready = 1; fire_cnt = 0;
    v = '{id: 4'd1, addr: 20'h00000, len: 8'd7, size: 3'd1, burst: 2'b01};
    ar_send(v);
    for (int i = 0; i < 20 && fire_cnt < 1; i++) step();
    check("mid_beat2_valid", sram_rd_cmd_valid, 1);
    check("mid_beat2_addr", sram_rd_cmd_addr, 1);
    sram_rd_resp_valid = 1; sram_rd_resp_data = 16'h1234;
    sram_rd_resp_meta = 4'd9; sram_rd_resp_last = 0;
    rst = 1;
    #1;
    check("async_cmd_valid", sram_rd_cmd_valid, 0);
    check("async_arready", s_axi_arready, 0);
    check("async_busy", busy, 0);
    check("rst_r_valid", s_axi_rvalid, 1);
    check("rst_r_data", s_axi_rdata, 16'h1234);
    check("rst_r_id", s_axi_rid, 9);
    sram_rd_resp_valid = 0;
    step(); step();
    rst = 0;
    step();
    check("post_rst_arready", s_axi_arready, 1);
    sb_en = 1; bp_en = 1;
    v = '{id: 4'd12, addr: 20'h00040, len: 8'd1, size: 3'd1, burst: 2'b01};
    exp_q.push_back({19'h20, 4'd12, 1'b0});
    exp_q.push_back({19'h21, 4'd12, 1'b1});
    ar_send(v);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
